// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Pure declarations; no timing.
// No handshake; consumed by the sequencer and its redirect arbiter.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } pc_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_TRAP,
        SRC_JUMP,
        SRC_BRANCH
    } redir_src_e;

    // Widest address the helper accepts; callers zero-extend into it.
    localparam int unsigned ADDR_MAX_W = 128;

    function automatic logic is_misaligned(input logic [ADDR_MAX_W-1:0] addr,
                                           input logic [ADDR_MAX_W-1:0] align_mask);
        return |(addr & align_mask);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-address handshake between the PC sequencer and instruction memory.
// Wires only; zero latency.
// pc/pc_valid held by the master until pc_ready is seen.
interface pc_sequencer_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            pc_ready;

    modport master (output pc, output pc_valid, input pc_ready);
    modport slave  (input pc, input pc_valid, output pc_ready);
endinterface

// File: rtl/pc_redirect_arb.sv
// Priority select of trap > jump > branch, target computation, alignment check.
// Purely combinational.
// No handshake; the caller decides whether the selected redirect is applied.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int STEP = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            trap_taken,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            jump_taken,
    input  logic            jump_abs,
    input  logic [XLEN-1:0] jump_offset,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_offset,
    output redir_src_e      redir_src,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    always_comb begin
        redir_src = SRC_NONE;
        target    = pc;
        if (trap_taken) begin
            redir_src = SRC_TRAP;
            target    = trap_vec;
        end else if (jump_taken) begin
            redir_src = SRC_JUMP;
            target    = jump_abs ? jump_offset : pc + jump_offset;
        end else if (branch_taken) begin
            redir_src = SRC_BRANCH;
            target    = pc + branch_offset;
        end
    end

    assign misaligned = (redir_src != SRC_NONE) &&
                        is_misaligned(ADDR_MAX_W'(target), ADDR_MAX_W'(STEP - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter with start/stop/stall control, redirects and fault capture.
// Registered outputs; a redirect or step shows on pc one cycle after it is asserted.
// pc/pc_valid hold while pc_ready is low; redirects do not wait for pc_ready.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              STEP      = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              stall,
    input  logic              trap_taken,
    input  logic [XLEN-1:0]   trap_vec,
    input  logic              jump_taken,
    input  logic              jump_abs,
    input  logic [XLEN-1:0]   jump_offset,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_offset,
    pc_sequencer_if.master    fetch,
    output logic              fault,
    output logic [XLEN-1:0]   fault_addr,
    output logic [CNT_W-1:0]  fetch_cnt
);

    pc_state_e        state_q, state_nxt;
    logic [XLEN-1:0]  pc_q, pc_nxt;
    logic             fault_q, fault_nxt;
    logic [XLEN-1:0]  fault_addr_q, fault_addr_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    redir_src_e       redir_src;
    logic [XLEN-1:0]  target;
    logic             misaligned;
    logic             fire;

    pc_redirect_arb #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_arb (
        .pc            (pc_q),
        .trap_taken    (trap_taken),
        .trap_vec      (trap_vec),
        .jump_taken    (jump_taken),
        .jump_abs      (jump_abs),
        .jump_offset   (jump_offset),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .redir_src     (redir_src),
        .target        (target),
        .misaligned    (misaligned)
    );

    // Counting follows the handshake alone, so a fetch accepted alongside a redirect still counts.
    assign fire = (state_q == ST_RUN) && fetch.pc_ready && !stall;

    always_comb begin
        state_nxt      = state_q;
        pc_nxt         = pc_q;
        fault_nxt      = fault_q;
        fault_addr_nxt = fault_addr_q;
        cnt_nxt        = fire ? cnt_q + CNT_W'(1) : cnt_q;

        if (start) begin
            state_nxt = ST_RUN;
            pc_nxt    = RESET_VEC;
            fault_nxt = 1'b0;
        end else if (stall) begin
            state_nxt = state_q;
        end else if (stop && state_q != ST_IDLE) begin
            state_nxt = ST_IDLE;
            pc_nxt    = RESET_VEC;
        end else if (state_q == ST_RUN) begin
            if (redir_src != SRC_NONE) begin
                if (misaligned) begin
                    state_nxt      = ST_HALT;
                    fault_nxt      = 1'b1;
                    fault_addr_nxt = target;
                end else begin
                    pc_nxt = target;
                end
            end else if (fetch.pc_ready) begin
                pc_nxt = pc_q + XLEN'(STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_VEC;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_nxt;
            pc_q         <= pc_nxt;
            fault_q      <= fault_nxt;
            fault_addr_q <= fault_addr_nxt;
            cnt_q        <= cnt_nxt;
        end
    end

    assign fetch.pc       = pc_q;
    assign fetch.pc_valid = (state_q == ST_RUN);
    assign fault          = fault_q;
    assign fault_addr     = fault_addr_q;
    assign fetch_cnt      = cnt_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer replacing the fixed 64-bit single-step PC register at the front of the fetch stage. Generates the fetch address with a valid/ready handshake toward the instruction memory, applies trap/jump/branch redirects in a fixed priority, and detects misaligned targets (halting with a fault report). Also keeps a wrapping count of accepted fetches for the performance counters.

## Interface
Parameters:
- XLEN, 64, PC and offset width
- STEP, 4, sequential increment in bytes; power of two ≥ 1
- RESET_VEC, 0, PC loaded on reset and on start
- CNT_W, 32, fetch-counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: load RESET_VEC, enter RUN, clear fault
- stop  in  1  pulse: leave RUN, enter IDLE
- stall  in  1  freeze all state except rst/start effects
- trap_taken  in  1  redirect to trap_vec (absolute)
- trap_vec  in  XLEN  trap target
- jump_taken  in  1  jump redirect
- jump_abs  in  1  1: target = jump_offset; 0: target = pc + jump_offset
- jump_offset  in  XLEN  jump target or offset
- branch_taken  in  1  target = pc + branch_offset
- branch_offset  in  XLEN  signed offset
- pc_ready  in  1  fetch side accepts current pc
- pc  out  XLEN  current fetch address
- pc_valid  out  1  pc is a fetch request (RUN only)
- fault  out  1  misaligned target seen; sticky until start/rst
- fault_addr  out  XLEN  offending target
- fetch_cnt  out  CNT_W  accepted fetches, wraps

## Operation
- States: IDLE, RUN, HALT. pc_valid = (state == RUN).
- Priority per cycle: rst > start > stall > stop > trap > jump > branch > sequential.
- rst: state IDLE, pc = RESET_VEC, fault = 0, fault_addr = 0, fetch_cnt = 0.
- start (any state): state RUN, pc = RESET_VEC, fault = 0; fetch_cnt unchanged.
- stall: all registers hold; the handshake is not counted even if pc_ready = 1.
- stop in RUN or HALT: state IDLE, pc = RESET_VEC. Ignored in IDLE.
- Redirects act in RUN only and do not wait for pc_ready. The current pc is dropped unless the handshake completes in the same cycle.
- Target check: target[log2(STEP)-1:0] != 0 is misaligned. When a misaligned redirect wins arbitration: state HALT, fault = 1, fault_addr = target, pc holds.
- Aligned redirect: pc = target.
- Sequential: in RUN with pc_ready and no redirect, pc = pc + STEP.
- Arithmetic is modulo 2^XLEN; wrap-around is silent. Offsets are two's complement XLEN.
- fetch_cnt increments on pc_valid & pc_ready & !stall, including the cycle a redirect fires. It wraps at 2^CNT_W.
- In IDLE and HALT, redirects and pc_ready are ignored.

## Timing
- All outputs are registered; a redirect is visible on pc one cycle after it is asserted.
- start pulse at cycle N: pc_valid = 1 and pc = RESET_VEC at N+1.
- pc and pc_valid hold stable while pc_valid & !pc_ready and no redirect.
- Simultaneous start and stop: start wins. Simultaneous stall and redirect: the redirect is lost; the source must hold it.
- rst mid-RUN clears everything on the next edge, regardless of other inputs.

## Structure
- Shared package pc_pkg: state enum (IDLE/RUN/HALT), redirect-source enum, misalignment helper function.
- One sub-module, pc_redirect_arb: combinational priority select plus target and misalignment computation. The FSM, pc, fault and counter registers sit in the top.

## Test plan
All cases use XLEN=64, STEP=4, RESET_VEC=0x1000.
- rst, then start, pc_ready=1 for 3 cycles -> pc 0x1000, 0x1004, 0x1008, 0x100C; fetch_cnt = 3.
- pc_ready=0 for 2 cycles at pc=0x1008 -> pc holds 0x1008 with pc_valid=1; fetch_cnt unchanged.
- At pc=0x1010: branch_taken with offset -8 -> pc 0x1008. Jump abs 0x2000 together with branch -> pc 0x2000. Trap to 0x3000 together with jump -> pc 0x3000.
- Jump abs to 0x2002 -> state HALT, fault=1, fault_addr=0x2002, pc_valid=0, pc holds. Then start -> fault=0, pc=0x1000.
- stall=1 with branch_taken and pc_ready=1 -> pc, fetch_cnt and state unchanged. stop together with start -> RUN at 0x1000.
- pc=0xFFFF_FFFF_FFFF_FFFC with sequential step -> pc 0x0. fetch_cnt with CNT_W=4 wraps 15 -> 0. rst mid-RUN -> IDLE, pc=0x1000, fetch_cnt=0.
